// File: rtl/cla_nibble_sequencer_if.sv
// Operand/result bundle for the nibble-serial carry-lookahead adder.
// The requester drives the master side; the adder sits on the slave side.
interface cla_nibble_sequencer_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/cla_nibble_sequencer.sv
// W-bit adder built from one 4-bit carry-lookahead slice reused over the
// nibbles, least significant first; one result every NIBBLES+2 cycles.
module cla_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_nibble_sequencer_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   a_reg, a_next;
    logic [W-1:0]   b_reg, b_next;
    logic [W-1:0]   sum_reg, sum_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           carry_reg, carry_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic           cout_reg, cout_next;
    logic           ovf_reg, ovf_next;

    // Shared slice operates on the nibble selected by the counter
    logic [3:0] slice_a, slice_b, g, p, slice_sum;
    logic [4:0] c;
    logic       last_nibble;

    assign slice_a     = a_reg[{cnt_reg, 2'b00} +: 4];
    assign slice_b     = b_reg[{cnt_reg, 2'b00} +: 4];
    assign last_nibble = (cnt_reg == CW'(NIBBLES - 1));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bit
            assign g[gi]         = slice_a[gi] & slice_b[gi];
            assign p[gi]         = slice_a[gi] ^ slice_b[gi];
            assign slice_sum[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    // Flattened lookahead: every carry depends only on g, p and c0
    assign c[0] = carry_reg;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            sum_reg   <= sum_next;
            cnt_reg   <= cnt_next;
            carry_reg <= carry_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        sum_next   = sum_reg;
        cnt_next   = cnt_reg;
        carry_next = carry_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    a_next     = bus.a;
                    b_next     = bus.b;
                    carry_next = bus.cin;
                    cnt_next   = '0;
                    busy_next  = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                sum_next[{cnt_reg, 2'b00} +: 4] = slice_sum;
                carry_next = c[4];
                if (last_nibble) begin
                    cnt_next   = '0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                    cout_next  = c[4];
                    ovf_next   = c[3] ^ c[4];
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule

// File: doc/cla_nibble_sequencer.md
CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, a request to begin an addition.
REQ-005 The block SHALL have port a, input, W, operand A.
REQ-006 The block SHALL have port b, input, W, operand B.
REQ-007 The block SHALL have port cin, input, 1, carry-in to the least significant nibble.
REQ-008 The block SHALL have port busy, output, 1, high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port sum, output, W, the registered result.
REQ-011 The block SHALL have port cout, output, 1, carry out of the most significant nibble.
REQ-012 The block SHALL have port ovf, output, 1, two's-complement signed overflow of the W-bit sum.

Function
REQ-013 The block SHALL implement one internal combinational 4-bit carry-lookahead slice: per-bit generate g=a&b and propagate p=a^b; c1..c4 from the lookahead equations, not rippled; slice sum = p^{c3..c0}.
REQ-014 The block SHALL time-share that single slice across the nibbles, least significant nibble first.
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 IDLE -> ADD SHALL occur on an edge with start=1; on that edge the block latches a, b and cin, clears the nibble counter to 0, and sets busy=1.
REQ-017 In ADD, each edge SHALL write the slice result into sum[4k+3:4k] for counter k, load the carry register with c4, and increment k.
REQ-018 ADD -> DONE SHALL occur on the edge that processes k = NIBBLES-1.
REQ-019 On that same edge, busy SHALL fall and done, cout and ovf SHALL be registered.
REQ-020 ovf SHALL equal carry-into-MSB XOR carry-out-of-MSB for the final nibble.
REQ-021 DONE -> IDLE SHALL occur unconditionally on the next edge, and done SHALL clear.
REQ-022 done SHALL be high for exactly one cycle per accepted start.
REQ-023 Latency: done SHALL be high in the cycle beginning NIBBLES edges after the accepting edge (4 edges at default).
REQ-024 The block SHALL ignore start in ADD and DONE; it SHALL NOT queue a request, and the latched operands SHALL NOT change.
REQ-025 A start held high continuously SHALL be re-accepted on the first edge in IDLE, giving a throughput of one result per NIBBLES+2 cycles.
REQ-026 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-027 sum, cout and ovf SHALL hold their last values in IDLE until the next accepted start.
REQ-028 During ADD, sum SHALL update nibble by nibble; sum is valid only while done=1 and after it.
REQ-029 The nibble counter SHALL be sized ceil(log2(NIBBLES)), minimum 1 bit, and SHALL NOT wrap within an operation.

Reset
REQ-030 Asserting rst SHALL immediately, without waiting for clk, force state=IDLE, counter=0, carry register=0, busy=0, done=0, sum=0, cout=0 and ovf=0.
REQ-031 Reset mid-ADD SHALL abort the operation with no done pulse; the partial sum SHALL be cleared.
REQ-032 start SHALL be ignored while rst=1; the first possible acceptance is the first edge after rst deasserts.

Verification
REQ-033 Stimulus a=0x1234, b=0x4321, cin=0, start pulse -> done 4 edges later with sum=0x5555, cout=0, ovf=0; busy high for exactly 4 cycles.
REQ-034 Stimulus a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-035 Stimulus a=0x8000, b=0x8000, cin=1 -> sum=0x0001, cout=1, ovf=1; a=0x000F, b=0x0000, cin=1 -> sum=0x0010, exercising carry across a nibble boundary.
REQ-036 Stimulus: start 0x0005+0x0000, then pulse start with a=0xAAAA two cycles later -> only one done pulse, with sum=0x0005.
REQ-037 Stimulus: start held high for 20 cycles with 0x0101+0x0101 -> done pulses every 6 cycles, each with sum=0x0202.
REQ-038 Stimulus: assert rst asynchronously after the second ADD cycle -> outputs are zero before the next clk edge, no done pulse follows, and a subsequent start completes normally.
